// File: rtl/mem_pkg.sv
// Shared definitions for the playfield reader: FSM state encoding, the
// number of piece cells, and default geometry.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int CELLS          = 4;
  localparam int DEF_MEM_WIDTH  = 4;
  localparam int DEF_MEM_HEIGHT = 4;
  localparam int DEF_WIDTH      = 8;

endpackage : mem_pkg

// File: rtl/mem_reader_reg.sv
// Loadable register holding one playfield column word; clears on reset.
module mem_reader_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // NOTE: the snapshot storage is reset so a pass started right after reset
  // never sees stale data from before it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule : mem_reader_reg

// File: rtl/mem_reader.sv
// Piece collision / full-row checker over a snapshot of the playfield.
// Define MEM_READER_ROW_SCAN_EN to enable the full-row SCAN state.
module mem_reader
  import mem_pkg::*;
#(
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int MEM_HEIGHT = DEF_MEM_HEIGHT,
  parameter int WIDTH      = DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH*CELLS-1:0]     coord_x,
  input  logic [WIDTH*CELLS-1:0]     coord_y,
  input  logic [WIDTH*MEM_WIDTH-1:0] field_bus,
  output logic                       busy,
  output logic                       done,
  output logic                       collision,
  output logic [MEM_HEIGHT-1:0]      full_row_mask
);

  localparam int               IDX_W    = $clog2(CELLS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS);
  localparam logic [WIDTH-1:0] X_LIM    = WIDTH'(MEM_WIDTH);
  localparam logic [WIDTH-1:0] Y_LIM    = WIDTH'(MEM_HEIGHT);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cell_idx_q, cell_idx_d;
  logic             coll_q, coll_d;
  logic [WIDTH-1:0] x_q [CELLS];
  logic [WIDTH-1:0] y_q [CELLS];
  logic [WIDTH-1:0] field_q [MEM_WIDTH];
  logic [WIDTH-1:0] cur_x, cur_y;
  logic             hit, cell_bad, load;

  assign load = (state_q == ST_IDLE) && start;

  for (genvar c = 0; c < MEM_WIDTH; c++) begin : g_col
    mem_reader_reg #(.WIDTH(WIDTH)) u_col (
      .clk    (clk),
      .rst    (rst),
      .load_i (load),
      .d_i    (field_bus[WIDTH*(MEM_WIDTH-c)-1 -: WIDTH]),
      .q_o    (field_q[c])
    );
  end

  // Cell 0 sits in the most significant slice of the coordinate buses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < CELLS; i++) begin
        x_q[i] <= coord_x[WIDTH*(CELLS-i)-1 -: WIDTH];
        y_q[i] <= coord_y[WIDTH*(CELLS-i)-1 -: WIDTH];
      end
    end
  end

  // Occupancy lookup only matches in-range coordinates, so wide values never
  // alias onto a real column or row.
  always_comb begin
    cur_x = '0;
    cur_y = '0;
    for (int i = 0; i < CELLS; i++) begin
      if (cell_idx_q == IDX_W'(i)) begin
        cur_x = x_q[i];
        cur_y = y_q[i];
      end
    end
    hit = 1'b0;
    for (int c = 0; c < MEM_WIDTH; c++) begin
      for (int r = 0; r < MEM_HEIGHT; r++) begin
        if (cur_x == WIDTH'(c) && cur_y == WIDTH'(r)) hit = field_q[c][r];
      end
    end
    cell_bad = (cur_x >= X_LIM) || (cur_y >= Y_LIM) || hit;
  end

`ifdef MEM_READER_ROW_SCAN_EN
  localparam int                ROW_W    = (MEM_HEIGHT > 1) ? $clog2(MEM_HEIGHT) : 1;
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(MEM_HEIGHT - 1);

  logic [ROW_W-1:0]      row_q, row_d;
  logic [MEM_HEIGHT-1:0] mask_q, mask_d;
  logic                  row_full;

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < MEM_WIDTH; c++) row_full = row_full & field_q[c][row_q];
  end

  assign full_row_mask = mask_q;
`else
  assign full_row_mask = '0;
`endif

  // NOTE: every next-state signal takes its hold value first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cell_idx_d = cell_idx_q;
    coll_d     = coll_q;
`ifdef MEM_READER_ROW_SCAN_EN
    row_d      = row_q;
    mask_d     = mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CHECK;
          cell_idx_d = '0;
          coll_d     = 1'b0;
`ifdef MEM_READER_ROW_SCAN_EN
          row_d      = '0;
          mask_d     = '0;
`endif
        end
      end
      ST_CHECK: begin
        // The cycle after the last cell is tested hands off to the next phase.
        if (cell_idx_q == LAST_IDX) begin
`ifdef MEM_READER_ROW_SCAN_EN
          state_d = ST_SCAN;
`else
          state_d = ST_DONE;
`endif
        end else begin
          coll_d     = coll_q | cell_bad;
          cell_idx_d = cell_idx_q + IDX_W'(1);
        end
      end
`ifdef MEM_READER_ROW_SCAN_EN
      ST_SCAN: begin
        mask_d[row_q] = row_full;
        if (row_q == LAST_ROW) state_d = ST_DONE;
        else                   row_d   = row_q + ROW_W'(1);
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cell_idx_q <= '0;
      coll_q     <= 1'b0;
`ifdef MEM_READER_ROW_SCAN_EN
      row_q      <= '0;
      mask_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cell_idx_q <= cell_idx_d;
      coll_q     <= coll_d;
`ifdef MEM_READER_ROW_SCAN_EN
      row_q      <= row_d;
      mask_q     <= mask_d;
`endif
    end
  end

  assign busy      = (state_q == ST_CHECK) || (state_q == ST_SCAN);
  assign done      = (state_q == ST_DONE);
  assign collision = coll_q;

endmodule : mem_reader

// File: tb/tb_mem_reader.sv
// Self-checking bench for mem_reader: behavioural pass model plus directed
// and randomized passes; honours MEM_READER_ROW_SCAN_EN like the design.
module tb_mem_reader;

  localparam int MW = 4;
  localparam int MH = 4;
  localparam int W  = 8;
`ifdef MEM_READER_ROW_SCAN_EN
  localparam int LAT     = 4 + MH + 1;
  localparam bit SCAN_ON = 1'b1;
`else
  localparam int LAT     = 5;
  localparam bit SCAN_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [W*4-1:0]    coord_x = '0;
  logic [W*4-1:0]    coord_y = '0;
  logic [W*MW-1:0]   field_bus = '0;
  logic              busy, done, collision;
  logic [MH-1:0]     full_row_mask;

  int total = 0;
  int bad   = 0;

  mem_reader #(.MEM_WIDTH(MW), .MEM_HEIGHT(MH), .WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .coord_x       (coord_x),
    .coord_y       (coord_y),
    .field_bus     (field_bus),
    .busy          (busy),
    .done          (done),
    .collision     (collision),
    .full_row_mask (full_row_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level result of a pass, evaluated directly on the packed buses.
  function automatic logic model_coll(input logic [W*4-1:0] cx, input logic [W*4-1:0] cy,
                                      input logic [W*MW-1:0] fb);
    logic c;
    int   x, y;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = int'(cx[W*(3-i) +: W]);
      y = int'(cy[W*(3-i) +: W]);
      if (x >= MW || y >= MH) c = 1'b1;
      else if (fb[W*(MW-1-x) + y]) c = 1'b1;
    end
    return c;
  endfunction

  function automatic logic [MH-1:0] model_mask(input logic [W*MW-1:0] fb);
    logic [MH-1:0] m;
    for (int r = 0; r < MH; r++) begin
      m[r] = 1'b1;
      for (int c = 0; c < MW; c++) m[r] = m[r] & fb[W*(MW-1-c) + r];
    end
    return m;
  endfunction

  // m_k: edges since the accepted start (-1 when idle).
  int            m_k = -1;
  logic          m_coll = 1'b0;
  logic [MH-1:0] m_mask = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k    = -1;
      m_coll = 1'b0;
      m_mask = '0;
    end else if (m_k < 0) begin
      if (start) begin
        m_k    = 0;
        m_coll = model_coll(coord_x, coord_y, field_bus);
        m_mask = SCAN_ON ? model_mask(field_bus) : '0;
      end
    end else if (m_k == LAT) begin
      m_k = -1;
    end else begin
      m_k++;
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_k >= 0 && m_k < LAT));
    check("done", 32'(done), 32'(m_k == LAT));
    if (m_k < 0 || m_k == LAT) begin
      check("collision", 32'(collision), 32'(m_coll));
      check("row_mask", 32'(full_row_mask), 32'(m_mask));
    end
  end

  // Returns at the negedge where done is seen; lat counts edges after start.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_pass(input string name, input logic [W*MW-1:0] fb,
                          input logic [W*4-1:0] cx, input logic [W*4-1:0] cy,
                          input logic exp_c, input logic [MH-1:0] exp_m);
    int lat;
    @(posedge clk); #1;
    field_bus = fb; coord_x = cx; coord_y = cy; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check({name, "_latency"}, 32'(lat), 32'(LAT));
    check({name, "_collision"}, 32'(collision), 32'(exp_c));
    check({name, "_mask"}, 32'(full_row_mask), 32'(exp_m));
  endtask

  task automatic rand_inputs();
    logic [W-1:0] common;
    common = W'($urandom);
    for (int c = 0; c < MW; c++) begin
      if ($urandom_range(0, 2) == 0) field_bus[W*(MW-1-c) +: W] = W'($urandom);
      else field_bus[W*(MW-1-c) +: W] = common | W'($urandom & $urandom);
    end
    for (int i = 0; i < 4; i++) begin
      coord_x[W*(3-i) +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, MW-1));
      coord_y[W*(3-i) +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, MH-1));
    end
  endtask

  localparam logic [W*4-1:0] X_ROW  = {8'd0, 8'd1, 8'd2, 8'd3};
  localparam logic [W*4-1:0] Y_ZERO = {8'd0, 8'd0, 8'd0, 8'd0};
  localparam logic [W*4-1:0] Y_THREE = {8'd3, 8'd3, 8'd3, 8'd3};

  initial begin
    int lat;
    int n_done;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_collision", 32'(collision), 32'd0);
    check("reset_mask", 32'(full_row_mask), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_pass("empty", '0, X_ROW, Y_ZERO, 1'b0, 4'b0000);
    run_pass("col2_hit", {8'h00, 8'h00, 8'h01, 8'h00}, X_ROW, Y_ZERO, 1'b1, 4'b0000);
    run_pass("rows_0_2", {4{8'h05}}, X_ROW, Y_THREE, 1'b0, SCAN_ON ? 4'b0101 : 4'b0000);
    run_pass("x_is_4", '0, {8'd0, 8'd1, 8'd2, 8'h04}, Y_ZERO, 1'b1, 4'b0000);
    run_pass("x_is_ff", '0, {8'hFF, 8'd1, 8'd2, 8'd3}, Y_ZERO, 1'b1, 4'b0000);
    run_pass("y_is_4", '0, X_ROW, {8'd0, 8'd4, 8'd0, 8'd0}, 1'b1, 4'b0000);
    run_pass("full_field", {4{8'h0F}}, X_ROW, Y_ZERO, 1'b1, SCAN_ON ? 4'b1111 : 4'b0000);

    // Restart attempts and input churn mid-pass.
    @(posedge clk); #1;
    field_bus = '0; coord_x = X_ROW; coord_y = Y_ZERO; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; field_bus = {4{8'hFF}}; coord_x = {4{8'hFF}};
    @(posedge clk); #1;
    start = 1'b0;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        check("midpass_collision", 32'(collision), 32'd0);
        check("midpass_mask", 32'(full_row_mask), 32'd0);
      end
    end
    check("midpass_done_count", 32'(n_done), 32'd1);
    field_bus = '0; coord_x = X_ROW;

    // Start held through DONE: ignored there, accepted on the next IDLE cycle.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("b2b_first_latency", 32'(lat), 32'(LAT));
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b_done_cycle_ignored", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("b2b_second_latency", 32'(lat), 32'(LAT));

    // Reset in the middle of a pass.
    @(posedge clk); #1;
    field_bus = {4{8'h0F}}; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_collision", 32'(collision), 32'd0);
    check("midreset_mask", 32'(full_row_mask), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midreset_no_done", 32'(n_done), 32'd0);
    run_pass("after_reset", {8'h00, 8'h02, 8'h00, 8'h00}, X_ROW, {8'd0, 8'd1, 8'd0, 8'd0},
             1'b1, 4'b0000);

    // Randomized passes checked by the model.
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      rand_inputs();
      start = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 start = 1'b0;
      repeat (2) begin
        @(posedge clk); #1;
        if ($urandom_range(0, 1) == 1) rand_inputs();
        start = 1'($urandom_range(0, 1));
      end
      start = 1'b0;
      wait_done(lat);
      check("rand_done_seen", 32'(lat >= 0), 32'd1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mem_reader
